// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants, ID instruction field positions and arbiter state encoding
// for the register file write-port arbiter.
package rf_write_arbiter_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_INDEX_WIDTH = 4;
  localparam int DEF_NUM_REGS    = 16;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard of registers awaiting MC results plus the ID-stage hazard compare.
// Set/clear land at the posedge; hazard is combinational from the current busy vector.
module rf_scoreboard
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   issue_vld_i,
  input  logic [DATA_WIDTH-1:0]  instr_i,
  input  logic                   clr_vld_i,
  input  logic [INDEX_WIDTH-1:0] clr_idx_i,
  output logic [NUM_REGS-1:0]    busy_o,
  output logic                   hazard_o
);

  logic [NUM_REGS-1:0]    busy_q, busy_d;
  logic [INDEX_WIDTH-1:0] rs1, rs2, rd;

  assign rs1 = instr_i[RS1_LSB +: INDEX_WIDTH];
  assign rs2 = instr_i[RS2_LSB +: INDEX_WIDTH];
  assign rd  = instr_i[RD_LSB  +: INDEX_WIDTH];

  // Clear is applied first so a same-index set in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_vld_i) begin
      busy_d[clr_idx_i] = 1'b0;
    end
    if (issue_vld_i && (rd != '0)) begin
      busy_d[rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign hazard_o = busy_q[rs1] | busy_q[rs2] | busy_q[rd];

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the RF write port between WB (fixed priority) and a late MC unit; 0-cycle grant.
// WB is never back-pressured; MC waits on o_mc_ready and a starvation FSM requests a stall.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                   clk,
  input  logic                   i_rst_ID,
  input  logic                   i_wb_valid_WB,
  input  logic [INDEX_WIDTH-1:0] i_wb_rd_WB,
  input  logic [DATA_WIDTH-1:0]  i_wb_data_WB,
  input  logic                   i_mc_issue_ID,
  input  logic [DATA_WIDTH-1:0]  i_instr_ID,
  input  logic                   i_mc_valid,
  input  logic [INDEX_WIDTH-1:0] i_mc_rd,
  input  logic [DATA_WIDTH-1:0]  i_mc_data,
  output logic                   o_mc_ready,
  output logic                   o_write_en_WB,
  output logic [INDEX_WIDTH-1:0] o_rd_WB,
  output logic [DATA_WIDTH-1:0]  o_data_WB,
  output logic                   o_hazard_ID,
  output logic                   o_stall_req,
  output logic [NUM_REGS-1:0]    o_busy_vec
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  arb_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 mc_accept;
  logic                 sb_hazard;

  always_comb begin
    o_write_en_WB = 1'b0;
    o_rd_WB       = '0;
    o_data_WB     = '0;
    o_mc_ready    = 1'b0;
    if (!i_rst_ID) begin
      if (i_wb_valid_WB) begin
        o_write_en_WB = 1'b1;
        o_rd_WB       = i_wb_rd_WB;
        o_data_WB     = i_wb_data_WB;
      end else if (i_mc_valid) begin
        o_write_en_WB = 1'b1;
        o_rd_WB       = i_mc_rd;
        o_data_WB     = i_mc_data;
        o_mc_ready    = 1'b1;
      end
    end
  end

  assign mc_accept = o_mc_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_mc_valid && i_wb_valid_WB) begin
          state_d = WAIT;
          cnt_d   = CNT_WIDTH'(1);
        end
      end
      WAIT: begin
        if (mc_accept || !i_mc_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LIMIT) begin
          state_d = FORCE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      FORCE: begin
        if (mc_accept || !i_mc_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst_ID) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Driven straight from the state register so the hazard unit sees a clean flop.
  assign o_stall_req = (state_q == FORCE) && !i_rst_ID;

  rf_scoreboard #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst_i      (i_rst_ID),
    .issue_vld_i(i_mc_issue_ID),
    .instr_i    (i_instr_ID),
    .clr_vld_i  (mc_accept),
    .clr_idx_i  (i_mc_rd),
    .busy_o     (o_busy_vec),
    .hazard_o   (sb_hazard)
  );

  assign o_hazard_ID = sb_hazard && !i_rst_ID;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, priority, scoreboard, starvation and x0 cases.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        i_rst_ID;
  logic        i_wb_valid_WB;
  logic [3:0]  i_wb_rd_WB;
  logic [31:0] i_wb_data_WB;
  logic        i_mc_issue_ID;
  logic [31:0] i_instr_ID;
  logic        i_mc_valid;
  logic [3:0]  i_mc_rd;
  logic [31:0] i_mc_data;
  logic        o_mc_ready;
  logic        o_write_en_WB;
  logic [3:0]  o_rd_WB;
  logic [31:0] o_data_WB;
  logic        o_hazard_ID;
  logic        o_stall_req;
  logic [15:0] o_busy_vec;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .DATA_WIDTH  (32),
    .NUM_REGS    (16),
    .INDEX_WIDTH (4),
    .STARVE_LIMIT(4),
    .CNT_WIDTH   (3)
  ) dut (
    .clk          (clk),
    .i_rst_ID     (i_rst_ID),
    .i_wb_valid_WB(i_wb_valid_WB),
    .i_wb_rd_WB   (i_wb_rd_WB),
    .i_wb_data_WB (i_wb_data_WB),
    .i_mc_issue_ID(i_mc_issue_ID),
    .i_instr_ID   (i_instr_ID),
    .i_mc_valid   (i_mc_valid),
    .i_mc_rd      (i_mc_rd),
    .i_mc_data    (i_mc_data),
    .o_mc_ready   (o_mc_ready),
    .o_write_en_WB(o_write_en_WB),
    .o_rd_WB      (o_rd_WB),
    .o_data_WB    (o_data_WB),
    .o_hazard_ID  (o_hazard_ID),
    .o_stall_req  (o_stall_req),
    .o_busy_vec   (o_busy_vec)
  );

  // Advance one clock; inputs change 1ns after the edge, outputs settle 2ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_instr(input logic [3:0] rs1, input logic [3:0] rs2,
                                           input logic [3:0] rd);
    logic [31:0] v;
    v = 32'h0;
    v[18:15] = rs1;
    v[23:20] = rs2;
    v[10:7]  = rd;
    return v;
  endfunction

  task automatic idle_inputs();
    i_wb_valid_WB = 1'b0;
    i_wb_rd_WB    = 4'd0;
    i_wb_data_WB  = 32'h0;
    i_mc_issue_ID = 1'b0;
    i_instr_ID    = 32'h0;
    i_mc_valid    = 1'b0;
    i_mc_rd       = 4'd0;
    i_mc_data     = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst_ID   = 1'b1;
    i_mc_valid = 1'b1;
    i_mc_rd    = 4'd2;
    i_mc_data  = 32'h55;
    step(); step();
    #2;
    n_cmp++; if (o_mc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mc_ready got %b want 0", o_mc_ready); end
    n_cmp++; if (o_write_en_WB !== 1'b0) begin n_fail++; $display("FAIL reset_write_en got %b want 0", o_write_en_WB); end
    n_cmp++; if (o_busy_vec !== 16'h0) begin n_fail++; $display("FAIL reset_busy got %h want 0000", o_busy_vec); end
    n_cmp++; if (o_stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", o_stall_req); end
    n_cmp++; if (o_hazard_ID !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %b want 0", o_hazard_ID); end
    step();
    i_rst_ID = 1'b0;
    #2;
    n_cmp++; if (o_mc_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_mc_ready got %b want 1", o_mc_ready); end
    n_cmp++; if (o_rd_WB !== 4'd2 || o_data_WB !== 32'h55) begin n_fail++; $display("FAIL post_reset_mc_fields got rd=%0d data=%h want rd=2 data=00000055", o_rd_WB, o_data_WB); end
    step();
    idle_inputs();
  endtask

  task automatic test_priority();
    i_wb_valid_WB = 1'b1; i_wb_rd_WB = 4'd5; i_wb_data_WB = 32'hAAAA;
    i_mc_valid    = 1'b1; i_mc_rd    = 4'd7; i_mc_data    = 32'h1234;
    #2;
    n_cmp++; if (o_write_en_WB !== 1'b1 || o_rd_WB !== 4'd5 || o_data_WB !== 32'hAAAA) begin n_fail++; $display("FAIL prio_wb got en=%b rd=%0d data=%h want en=1 rd=5 data=0000aaaa", o_write_en_WB, o_rd_WB, o_data_WB); end
    n_cmp++; if (o_mc_ready !== 1'b0) begin n_fail++; $display("FAIL prio_mc_blocked got %b want 0", o_mc_ready); end
    step();
    i_wb_valid_WB = 1'b0;
    #2;
    n_cmp++; if (o_write_en_WB !== 1'b1 || o_rd_WB !== 4'd7 || o_data_WB !== 32'h1234) begin n_fail++; $display("FAIL prio_mc got en=%b rd=%0d data=%h want en=1 rd=7 data=00001234", o_write_en_WB, o_rd_WB, o_data_WB); end
    n_cmp++; if (o_mc_ready !== 1'b1) begin n_fail++; $display("FAIL prio_mc_ready got %b want 1", o_mc_ready); end
    step();
    idle_inputs();
    #2;
    n_cmp++; if (o_write_en_WB !== 1'b0 || o_rd_WB !== 4'd0 || o_data_WB !== 32'h0) begin n_fail++; $display("FAIL idle_outputs got en=%b rd=%0d data=%h want all zero", o_write_en_WB, o_rd_WB, o_data_WB); end
  endtask

  task automatic test_scoreboard();
    i_mc_issue_ID = 1'b1;
    i_instr_ID    = mk_instr(4'd0, 4'd0, 4'd3);
    step();
    i_mc_issue_ID = 1'b0;
    i_instr_ID    = mk_instr(4'd1, 4'd3, 4'd2);
    #2;
    n_cmp++; if (o_busy_vec !== 16'h0008) begin n_fail++; $display("FAIL sb_set got %h want 0008", o_busy_vec); end
    n_cmp++; if (o_hazard_ID !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_rs2 got %b want 1", o_hazard_ID); end
    i_instr_ID = mk_instr(4'd3, 4'd1, 4'd2);
    #1;
    n_cmp++; if (o_hazard_ID !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_rs1 got %b want 1", o_hazard_ID); end
    i_instr_ID = mk_instr(4'd1, 4'd2, 4'd3);
    #1;
    n_cmp++; if (o_hazard_ID !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_rd got %b want 1", o_hazard_ID); end
    i_instr_ID = mk_instr(4'd4, 4'd2, 4'd1);
    #1;
    n_cmp++; if (o_hazard_ID !== 1'b0) begin n_fail++; $display("FAIL sb_no_hazard got %b want 0", o_hazard_ID); end
    step();
    i_instr_ID = mk_instr(4'd1, 4'd3, 4'd2);
    i_mc_valid = 1'b1; i_mc_rd = 4'd3; i_mc_data = 32'hD00D;
    #2;
    n_cmp++; if (o_hazard_ID !== 1'b1) begin n_fail++; $display("FAIL sb_no_bypass got %b want 1", o_hazard_ID); end
    step();
    i_mc_valid = 1'b0;
    #2;
    n_cmp++; if (o_busy_vec !== 16'h0000) begin n_fail++; $display("FAIL sb_clear got %h want 0000", o_busy_vec); end
    n_cmp++; if (o_hazard_ID !== 1'b0) begin n_fail++; $display("FAIL sb_hazard_clear got %b want 0", o_hazard_ID); end
    step();
    idle_inputs();
  endtask

  task automatic test_set_clear_same();
    i_mc_issue_ID = 1'b1;
    i_instr_ID    = mk_instr(4'd0, 4'd0, 4'd3);
    step();
    i_mc_valid = 1'b1; i_mc_rd = 4'd3;
    i_instr_ID = mk_instr(4'd0, 4'd0, 4'd3);
    step();
    i_mc_issue_ID = 1'b0;
    i_mc_valid    = 1'b0;
    #2;
    n_cmp++; if (o_busy_vec !== 16'h0008) begin n_fail++; $display("FAIL set_wins got %h want 0008", o_busy_vec); end
    i_mc_issue_ID = 1'b1;
    i_instr_ID    = mk_instr(4'd0, 4'd0, 4'd6);
    i_mc_valid    = 1'b1; i_mc_rd = 4'd3;
    step();
    i_mc_issue_ID = 1'b0;
    i_mc_valid    = 1'b0;
    #2;
    n_cmp++; if (o_busy_vec !== 16'h0040) begin n_fail++; $display("FAIL set_clear_diff got %h want 0040", o_busy_vec); end
    i_mc_valid = 1'b1; i_mc_rd = 4'd6;
    step();
    idle_inputs();
    #2;
    n_cmp++; if (o_busy_vec !== 16'h0000) begin n_fail++; $display("FAIL set_clear_drain got %h want 0000", o_busy_vec); end
  endtask

  task automatic test_starvation();
    i_wb_valid_WB = 1'b1; i_wb_rd_WB = 4'd1; i_wb_data_WB = 32'h11;
    i_mc_valid    = 1'b1; i_mc_rd    = 4'd9; i_mc_data    = 32'h99;
    for (int c = 0; c < 5; c++) begin
      #2;
      n_cmp++; if (o_stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_early cycle %0d got %b want 0", c, o_stall_req); end
      step();
    end
    #2;
    n_cmp++; if (o_stall_req !== 1'b1) begin n_fail++; $display("FAIL starve_rise got %b want 1", o_stall_req); end
    n_cmp++; if (o_mc_ready !== 1'b0 || o_rd_WB !== 4'd1) begin n_fail++; $display("FAIL starve_wb_prio got ready=%b rd=%0d want ready=0 rd=1", o_mc_ready, o_rd_WB); end
    step();
    i_wb_valid_WB = 1'b0;
    #2;
    n_cmp++; if (o_stall_req !== 1'b1 || o_mc_ready !== 1'b1) begin n_fail++; $display("FAIL starve_drain got stall=%b ready=%b want 1 1", o_stall_req, o_mc_ready); end
    step();
    i_mc_valid = 1'b0;
    #2;
    n_cmp++; if (o_stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_release got %b want 0", o_stall_req); end
    idle_inputs();
    step();
  endtask

  task automatic test_drop_and_reset_force();
    // MC valid drop in WAIT restarts the count.
    i_wb_valid_WB = 1'b1; i_mc_valid = 1'b1; i_mc_rd = 4'd4;
    step(); step(); step();
    i_mc_valid = 1'b0;
    step();
    i_mc_valid = 1'b1;
    for (int c = 0; c < 5; c++) step();
    #2;
    n_cmp++; if (o_stall_req !== 1'b1) begin n_fail++; $display("FAIL restart_force got %b want 1", o_stall_req); end
    i_rst_ID = 1'b1;
    #1;
    n_cmp++; if (o_stall_req !== 1'b0 || o_write_en_WB !== 1'b0) begin n_fail++; $display("FAIL reset_in_force got stall=%b en=%b want 0 0", o_stall_req, o_write_en_WB); end
    step();
    i_rst_ID = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      n_cmp++; if (o_stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_cleared_fsm cycle %0d got %b want 0", c, o_stall_req); end
      step();
    end
    idle_inputs();
    step(); step();
  endtask

  task automatic test_x0();
    i_mc_issue_ID = 1'b1;
    i_instr_ID    = mk_instr(4'd0, 4'd0, 4'd0);
    step();
    i_mc_issue_ID = 1'b0;
    #2;
    n_cmp++; if (o_busy_vec !== 16'h0000) begin n_fail++; $display("FAIL x0_busy got %h want 0000", o_busy_vec); end
    i_instr_ID = mk_instr(4'd0, 4'd5, 4'd8);
    #1;
    n_cmp++; if (o_hazard_ID !== 1'b0) begin n_fail++; $display("FAIL x0_hazard got %b want 0", o_hazard_ID); end
    i_wb_valid_WB = 1'b1; i_wb_rd_WB = 4'd0; i_wb_data_WB = 32'hFEED;
    #1;
    n_cmp++; if (o_write_en_WB !== 1'b1 || o_rd_WB !== 4'd0 || o_data_WB !== 32'hFEED) begin n_fail++; $display("FAIL x0_passthru got en=%b rd=%0d data=%h want 1 0 0000feed", o_write_en_WB, o_rd_WB, o_data_WB); end
    step();
    idle_inputs();
  endtask

  initial begin
    i_rst_ID = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_priority();
    test_scoreboard();
    test_set_clear_same();
    test_starvation();
    test_drop_and_reset_force();
    test_x0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline writeback (WB) and a multi-cycle execution unit (MC, e.g. divider) that returns results late.
- Holds a busy scoreboard of registers awaiting MC results and flags ID-stage hazards.
- Runs a starvation FSM that requests a pipeline stall so that MC results eventually drain.
- Sits between the WB stage, the MC unit and the register file write port.

Parameters:
- DATA_WIDTH, 32, register data width
- NUM_REGS, 16, architectural registers; x0 hardwired zero
- INDEX_WIDTH, 4, register index width
- STARVE_LIMIT, 4, consecutive cycles MC may wait before a stall is requested (>=1)
- CNT_WIDTH, 3, starvation counter width; must hold STARVE_LIMIT

Ports:
- clk  in  1  clock
- i_rst_ID  in  1  synchronous active-high reset
- i_wb_valid_WB  in  1  pipeline writeback request
- i_wb_rd_WB  in  INDEX_WIDTH  pipeline destination register
- i_wb_data_WB  in  DATA_WIDTH  pipeline write data
- i_mc_issue_ID  in  1  MC op leaves ID this cycle (not stalled)
- i_instr_ID  in  DATA_WIDTH  ID instruction; rs1=[18:15], rs2=[23:20], rd=[10:7]
- i_mc_valid  in  1  MC result available
- i_mc_rd  in  INDEX_WIDTH  MC result destination
- i_mc_data  in  DATA_WIDTH  MC result data
- o_mc_ready  out  1  MC result accepted this cycle
- o_write_en_WB  out  1  register file write enable
- o_rd_WB  out  INDEX_WIDTH  register file write index
- o_data_WB  out  DATA_WIDTH  register file write data
- o_hazard_ID  out  1  ID must stall: rs1/rs2/rd busy
- o_stall_req  out  1  starvation stall request to hazard unit
- o_busy_vec  out  NUM_REGS  scoreboard (bit i = register i pending)

Behaviour:
- Reset (i_rst_ID high at posedge):
  - busy_vec=0, counter=0, state=IDLE.
  - While reset is asserted, o_mc_ready=0, o_write_en_WB=0, o_stall_req=0 and o_hazard_ID=0, overriding normal grants.
  - Reset mid-wait drops the pending MC grant; MC must keep i_mc_valid high.
- Grant (combinational, same cycle):
  - WB has fixed priority and is never back-pressured.
  - wb_valid=1: output WB fields; o_mc_ready=0.
  - wb_valid=0 and mc_valid=1: output MC fields; o_mc_ready=1; handshake completes at the posedge.
  - Neither valid: o_write_en_WB=0, o_rd/o_data=0.
  - Writes to rd=0 pass through; the register file ignores them.
- Scoreboard (updated at posedge):
  - i_mc_issue_ID with rd[10:7]!=0 sets busy[rd].
  - Accepted MC result (mc_valid & o_mc_ready) clears busy[i_mc_rd].
  - Set and clear on the same index in the same cycle: set wins.
  - busy[0] is never set.
- Hazard:
  - o_hazard_ID = busy[rs1] | busy[rs2] | busy[rd], combinational from current busy_vec.
  - No bypass of MC data: a register cleared this cycle is still busy this cycle.
  - ID must not assert i_mc_issue_ID while o_hazard_ID is high; if it does, busy stays set (no error).
- Starvation FSM (counter increments once per cycle in WAIT):
  - IDLE: mc_valid & wb_valid -> WAIT, counter=1; otherwise stay.
  - WAIT:
    - MC accepted -> IDLE, counter=0.
    - mc_valid dropped -> IDLE, counter=0.
    - counter==STARVE_LIMIT while still blocked -> FORCE.
    - otherwise counter+1.
  - FORCE: o_stall_req=1 (registered, first asserted the cycle after entry).
    - MC accepted or mc_valid dropped -> IDLE, o_stall_req=0 next cycle.
    - WB keeps priority in FORCE; in-flight instructions drain and create the bubble.
- Latency:
  - Grant to register file write: 0 cycles, written at the same posedge as the handshake.
  - Readable via the register file's negedge read of the same cycle.

Decomposition:
- Shared package: INDEX_WIDTH/DATA_WIDTH constants, rs1/rs2/rd bit-slice localparams, arb_state_t enum {IDLE, WAIT, FORCE}.
- One natural sub-module: rf_scoreboard (busy_vec set/clear plus hazard compare).
- Arbiter mux and FSM stay in the top module.

Test Plan:
- Reset: assert i_rst_ID with mc_valid=1 -> o_mc_ready=0, o_busy_vec=0, o_stall_req=0; after release and wb_valid=0, o_mc_ready=1 the same cycle.
- Priority: wb_valid=1 rd=5 data=0xAAAA and mc_valid=1 rd=7 data=0x1234 in the same cycle -> o_write_en=1, o_rd=5, o_data=0xAAAA, o_mc_ready=0; next cycle wb_valid=0 -> o_rd=7, o_data=0x1234, o_mc_ready=1.
- Scoreboard: issue MC with rd=3 -> busy_vec=0x0008; ID instr with rs2=3 -> o_hazard_ID=1; accept mc rd=3 -> busy_vec=0 next cycle and hazard clears.
- Simultaneous set/clear: accept mc rd=3 while issuing a new MC to rd=3 -> busy[3] stays 1.
- Starvation: STARVE_LIMIT=4, wb_valid held 1, mc_valid=1 -> o_stall_req rises 5 cycles after mc_valid; drop wb_valid -> mc accepted, o_stall_req=0 the next cycle.
- x0: issue MC with rd=0 -> busy_vec unchanged; ID instr with rs1=0 -> o_hazard_ID=0.
